// File: rtl/zr_irq_ctrl.sv
// Interrupt controller: level/edge pending capture, lowest-ID request to the core
// with an IDLE/REQ/GAP acknowledge FSM, and an ICB register slave.
module zr_irq_ctrl #(
    parameter int NSRC = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src_i,
    output logic            irq_o,
    output logic [4:0]      irq_id_o,
    input  logic            irq_ack_i,
    input  logic [4:0]      irq_id_i,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic            icb_cmd_read,
    input  logic [31:0]     icb_cmd_addr,
    input  logic [31:0]     icb_cmd_wdata,
    input  logic [3:0]      icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic [31:0]     icb_rsp_rdata,
    output logic            icb_rsp_err
);
    // Bits 1..NSRC are real sources; bit 0 (ID "none") and unused upper bits stay 0.
    localparam logic [31:0] SRC_MASK = 32'((64'd1 << (NSRC + 1)) - 64'd2);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_id, w_id_nxt;
    logic [31:0]     r_enable, r_edge, r_pend;
    logic [NSRC-1:0] r_src_q;
    logic            r_rsp_valid, r_rsp_err;
    logic [31:0]     r_rsp_rdata;

    logic [31:0] w_src, w_src_q, w_rise, w_cand, w_clr, w_pend_nxt;
    logic [31:0] w_lane_bits, w_wdata_m, w_rdata;
    logic [4:0]  w_sel;
    logic        w_any, w_held_live, w_ack_clr;
    logic        w_cmd_fire, w_err, w_wr;
    logic [1:0]  w_off;
    logic        w_unused;

    assign w_src   = 32'({irq_src_i, 1'b0});
    assign w_src_q = 32'({r_src_q, 1'b0});
    assign w_rise  = w_src & ~w_src_q;
    assign w_cand  = r_pend & r_enable;
    assign w_any   = |w_cand;

    always_comb begin
        w_sel = 5'd0;
        for (int k = NSRC; k >= 1; k--) begin
            if (w_cand[k]) w_sel = 5'(k);
        end
    end

    // ICB decode; only one transaction may be outstanding.
    assign w_cmd_fire  = icb_cmd_valid & ~r_rsp_valid;
    assign w_off       = icb_cmd_addr[3:2];
    assign w_err       = (|icb_cmd_addr[11:4]) | (~icb_cmd_read & (w_off == 2'd3));
    assign w_wr        = w_cmd_fire & ~icb_cmd_read & ~w_err;
    assign w_lane_bits = {{8{icb_cmd_wmask[3]}}, {8{icb_cmd_wmask[2]}},
                          {8{icb_cmd_wmask[1]}}, {8{icb_cmd_wmask[0]}}};
    assign w_wdata_m   = icb_cmd_wdata & w_lane_bits;
    assign w_unused    = ^{icb_cmd_addr[31:12], icb_cmd_addr[1:0]};

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            2'd0:    w_rdata = r_enable;
            2'd1:    w_rdata = r_edge;
            2'd2:    w_rdata = r_pend;
            default: w_rdata = {irq_o, 26'd0, irq_o ? r_id : 5'd0};
        endcase
    end

    // Clears only reach edge bits; a new rising edge in the same cycle wins.
    assign w_ack_clr  = (r_state == S_REQ) & irq_ack_i & (irq_id_i == r_id);
    assign w_clr      = ((w_wr && w_off == 2'd2) ? w_wdata_m : 32'd0)
                      | (w_ack_clr ? (32'd1 << r_id) : 32'd0);
    assign w_pend_nxt = ((r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & w_src)) & SRC_MASK;

    assign w_held_live = r_pend[r_id] & r_enable[r_id];

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQ;
                    w_id_nxt    = w_sel;
                end
            end
            S_REQ: begin
                if (irq_ack_i) begin
                    w_state_nxt = S_GAP;
                    w_id_nxt    = 5'd0;
                end else if (!w_held_live) begin
                    w_state_nxt = S_IDLE;
                    w_id_nxt    = 5'd0;
                end
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_id        <= 5'd0;
            r_enable    <= 32'd0;
            r_edge      <= 32'd0;
            r_pend      <= 32'd0;
            r_src_q     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            r_src_q <= irq_src_i;
            r_pend  <= w_pend_nxt;
            if (w_wr && w_off == 2'd0) r_enable <= ((r_enable & ~w_lane_bits) | w_wdata_m) & SRC_MASK;
            if (w_wr && w_off == 2'd1) r_edge   <= ((r_edge & ~w_lane_bits) | w_wdata_m) & SRC_MASK;
            if (w_cmd_fire) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (icb_cmd_read && !w_err) ? w_rdata : 32'd0;
            end else if (r_rsp_valid && icb_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign irq_o         = (r_state == S_REQ);
    assign irq_id_o      = r_id;
    assign icb_cmd_ready = ~r_rsp_valid;
    assign icb_rsp_valid = r_rsp_valid;
    assign icb_rsp_rdata = r_rsp_rdata;
    assign icb_rsp_err   = r_rsp_err;

endmodule

// File: doc/zr_irq_ctrl.md
# zr_irq_ctrl

Interrupt controller sitting between the peripheral subsystem and the CPU coreplex. Collects up to 31 peripheral interrupt lines (QSPI, UART, PWM, GPIO, …), latches them as level- or edge-triggered pending bits, and presents the lowest-numbered enabled pending source to the core on the `irq`/`irq_id` request interface. It completes the core's acknowledge handshake and exposes enable/mode/pending registers on an ICB slave port hung off the data peripheral bus.

## Interface
- `NSRC`, 31, number of sources (1..31); source IDs are 1..NSRC; ID 0 means "none".
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `irq_src_i`  in  NSRC  source lines, bit k-1 = source ID k, active-high, synchronous to `clk`.
- `irq_o`  out  1  interrupt request to core.
- `irq_id_o`  out  5  ID of the requested source; valid while `irq_o`=1.
- `irq_ack_i`  in  1  core acknowledge, single-cycle pulse.
- `irq_id_i`  in  5  ID the core is acknowledging, qualified by `irq_ack_i`.
- `icb_cmd_valid`/`icb_cmd_ready`  in/out  1  ICB command handshake.
- `icb_cmd_read`  in  1  1=read, 0=write.
- `icb_cmd_addr`  in  32  byte address; only bits [3:2] are decoded, bits [11:4] must be 0.
- `icb_cmd_wdata`  in  32  write data.
- `icb_cmd_wmask`  in  4  byte write enables.
- `icb_rsp_valid`/`icb_rsp_ready`  out/in  1  ICB response handshake.
- `icb_rsp_rdata`  out  32  read data; 0 on writes and errors.
- `icb_rsp_err`  out  1  error response.

## Operation
- Registers (bit k = source ID k; bit 0 and bits above NSRC read 0 and ignore writes):
  - 0x0 ENABLE, R/W, reset 0.
  - 0x4 EDGE, R/W, 1=edge-triggered, 0=level, reset 0.
  - 0x8 PENDING, R; write-1-to-clear for edge bits; writes to level bits have no effect.
  - 0xC CLAIM, R only: [4:0]=`irq_id_o` when `irq_o`=1, else 0; [31]=`irq_o`. A write returns err.
- Pending update each cycle:
  - Level source: pend = `irq_src_i`.
  - Edge source: set on 0→1 transition versus a registered copy of `irq_src_i`; cleared by ack of its ID or by SW W1C.
  - Set and clear in the same cycle: set wins.
- Request select: the lowest ID with pend&enable.
- Request FSM, reset to IDLE:
  - IDLE (`irq_o`=0): if any candidate exists, register the selected ID into `irq_id_o` and go to REQ.
  - REQ (`irq_o`=1, `irq_id_o` held stable): on `irq_ack_i` go to GAP.
    - On ack, if `irq_id_i` = `irq_id_o` and the source is edge, clear its pending bit.
    - Without ack, if the held ID loses pend or enable, go to IDLE (request withdrawn).
    - A higher-priority arrival does not preempt the held ID.
  - GAP (`irq_o`=0): one cycle unconditionally, then IDLE.
  - Ack with mismatched ID: still moves REQ→GAP; no pending bit is cleared.
  - Ack outside REQ: ignored.
- ICB: one outstanding transaction.
  - `icb_cmd_ready` = !`icb_rsp_valid`.
  - Response is registered and held until `icb_rsp_ready`.
  - Unmapped offset (addr[11:4]≠0) → `icb_rsp_err`=1, no state change.
  - The wmask byte lanes gate writes.

## Timing
- Reset values: `irq_o`=0, `irq_id_o`=0, `icb_cmd_ready`=1, `icb_rsp_valid`=0, `icb_rsp_rdata`=0, `icb_rsp_err`=0, FSM=IDLE, edge history=0.
- Source asserted in cycle N (enabled): pending visible in cycle N+1, `irq_o`=1 in cycle N+2.
- Ack in cycle M:
  - `irq_o`=0 in cycle M+1 (GAP).
  - The edge pending bit reads 0 from cycle M+1.
  - Next request at the earliest in cycle M+3.
- ICB command accepted in cycle C: `icb_rsp_valid`=1 in cycle C+1.
  - A write takes effect from cycle C+1.
  - A read returns the register value as of cycle C.
- Reset asserted mid-REQ: `irq_o` falls the cycle after reset is sampled; all pending bits are lost.

## Test plan
- Reset → all outputs at reset values; then read ENABLE/EDGE/PENDING/CLAIM → 0,0,0,0.
- ENABLE=0x0000_0006, level: assert src ID 2 at N → `irq_o`=1, `irq_id_o`=2 at N+2. Ack ID 2 with the source still high → GAP, then re-request ID 2 at M+3.
- EDGE=ENABLE=0x0000_0010: pulse src ID 4 one cycle → PENDING=0x10, request ID 4. Ack ID 4 → PENDING=0, `irq_o` stays 0.
- Priority: IDs 5 and 3 assert together → `irq_id_o`=3. ID 1 arrives during REQ → `irq_id_o` stays 3. After ack of 3, the next request is ID 1.
- Edge set and W1C in the same cycle on ID 7 → PENDING bit 7=1. Ack with `irq_id_i`=9 while `irq_id_o`=7 → FSM goes to GAP, bit 7 still 1, then re-request of ID 7.
- ICB checks:
  - Write wmask=0x1, data 0xFFFF_FFFF to ENABLE → ENABLE=0x0000_00FE.
  - Access to 0x10 → err=1.
  - Write to CLAIM → err=1.
  - Holding `icb_rsp_ready`=0 for 3 cycles → `icb_cmd_ready`=0 throughout.
